// File: rtl/rdx_bank_wr_cta_pkg.sv
// Shared types and constants for the CTA FFT bank-write stage.
// Holds the FSM encoding, the lane count, the legal radix range and the factor clamp.
package rdx_bank_wr_cta_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned NLanes     = 5;
  localparam int unsigned FactorMin  = 2;
  localparam int unsigned FactorMax  = 5;
  localparam int unsigned WDataInOut = 18;
  localparam int unsigned WBitsUsed  = 5;

  function automatic logic [2:0] clamp_factor(input logic [2:0] f);
    if (f < 3'(FactorMin)) return 3'(FactorMin);
    if (f > 3'(FactorMax)) return 3'(FactorMax);
    return f;
  endfunction

  function automatic logic factor_illegal(input logic [2:0] f);
    return (f < 3'(FactorMin)) || (f > 3'(FactorMax));
  endfunction

endpackage

// File: rtl/rdx_bank_wr_cta_msb_index.sv
// Priority encoder: returns (index of highest set bit)+1, or 0 for an all-zero vector.
module rdx_bank_wr_cta_msb_index #(
  parameter int unsigned Width = 18,
  parameter int unsigned OutW  = 5
) (
  input  logic [Width-1:0] vec_i,
  output logic [OutW-1:0]  idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < Width; i++) begin
      if (vec_i[i]) idx_o = OutW'(i + 1);
    end
  end

endmodule

// File: rtl/rdx_bank_wr_cta.sv
// Bank write stage of the mixed-radix CTA FFT: registers twiddled lanes onto five bank
// write ports, counts beats per stage, flags protocol errors and measures headroom.
module rdx_bank_wr_cta
  import rdx_bank_wr_cta_pkg::*;
#(
  parameter int unsigned wDataInOut = 18,
  parameter int unsigned wAddr      = 12,
  parameter int unsigned wCnt       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stage_start,
  input  logic [2:0]                   factor,
  input  logic [wCnt-1:0]              grp_num,
  input  logic                         in_val,
  input  logic signed [wDataInOut-1:0] din_real [NLanes],
  input  logic signed [wDataInOut-1:0] din_imag [NLanes],
  input  logic [wAddr-1:0]             addr_in  [NLanes],
  output logic [NLanes-1:0]            wr_en,
  output logic [wAddr-1:0]             wr_addr  [NLanes],
  output logic signed [wDataInOut-1:0] wr_real  [NLanes],
  output logic signed [wDataInOut-1:0] wr_imag  [NLanes],
  output logic                         busy,
  output logic                         stage_done,
  output logic [WBitsUsed-1:0]         bits_used,
  output logic                         err
);

  state_e                  state_q, state_d;
  logic [2:0]              factor_q, factor_d;
  logic [wCnt-1:0]         grp_q, grp_d, cnt_q, cnt_d;
  logic [wDataInOut-1:0]   acc_q, acc_d, acc_beat, beat_m;
  logic [WBitsUsed-1:0]    bits_q, bits_d, msb_idx;
  logic                    err_q, err_d;
  logic [NLanes-1:0]       lane_act, wr_en_q, wr_en_d;
  logic [wAddr-1:0]        wr_addr_q [NLanes];
  logic [wDataInOut-1:0]   wr_real_q [NLanes];
  logic [wDataInOut-1:0]   wr_imag_q [NLanes];

  // Sign-folded magnitude: leading sign copies become zeros, so the top set bit is headroom.
  function automatic logic [wDataInOut-1:0] fold(input logic [wDataInOut-1:0] x);
    return x ^ {wDataInOut{x[wDataInOut-1]}};
  endfunction

  always_comb begin
    beat_m = '0;
    for (int i = 0; i < NLanes; i++) begin
      lane_act[i] = (i < int'(factor_q));
      if (lane_act[i]) beat_m = beat_m | fold(din_real[i]) | fold(din_imag[i]);
    end
    acc_beat = acc_q | beat_m;
  end

  rdx_bank_wr_cta_msb_index #(
    .Width (wDataInOut),
    .OutW  (WBitsUsed)
  ) u_msb_index (
    .vec_i (acc_beat),
    .idx_o (msb_idx)
  );

  // State register plus all stage bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      factor_q <= '0;
      grp_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      bits_q   <= '0;
      err_q    <= 1'b0;
      wr_en_q  <= '0;
      for (int i = 0; i < NLanes; i++) begin
        wr_addr_q[i] <= '0;
        wr_real_q[i] <= '0;
        wr_imag_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      factor_q <= factor_d;
      grp_q    <= grp_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bits_q   <= bits_d;
      err_q    <= err_d;
      wr_en_q  <= wr_en_d;
      if (in_val) begin
        for (int i = 0; i < NLanes; i++) begin
          wr_addr_q[i] <= addr_in[i];
          wr_real_q[i] <= din_real[i];
          wr_imag_q[i] <= din_imag[i];
        end
      end
    end
  end

  // Next state: stage_start wins in every state and drops any coincident beat
  always_comb begin
    state_d  = state_q;
    factor_d = factor_q;
    grp_d    = grp_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bits_d   = bits_q;
    err_d    = err_q;
    if (stage_start) begin
      state_d  = StRun;
      factor_d = clamp_factor(factor);
      grp_d    = (grp_num == '0) ? wCnt'(1) : grp_num;
      cnt_d    = '0;
      acc_d    = '0;
      if (state_q == StRun || in_val || factor_illegal(factor) || grp_num == '0) err_d = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (in_val) begin
            acc_d = acc_beat;
            cnt_d = cnt_q + wCnt'(1);
            if (cnt_q == grp_q - wCnt'(1)) begin
              state_d = StDone;
              bits_d  = msb_idx;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          if (in_val) err_d = 1'b1;
        end
        default: begin
          if (in_val) err_d = 1'b1;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    wr_en_d = '0;
    if (state_q == StRun && in_val && !stage_start) wr_en_d = lane_act;
    busy       = (state_q == StRun);
    stage_done = (state_q == StDone);
  end

  assign wr_en     = wr_en_q;
  assign bits_used = bits_q;
  assign err       = err_q;

  always_comb begin
    for (int i = 0; i < NLanes; i++) begin
      wr_addr[i] = wr_addr_q[i];
      wr_real[i] = wr_real_q[i];
      wr_imag[i] = wr_imag_q[i];
    end
  end

endmodule

// File: tb/tb_rdx_bank_wr_cta.sv
// Self-checking bench for rdx_bank_wr_cta: directed and randomized stages against a
// stage-level reference model (beats remaining, peak magnitude, sticky error).
module tb_rdx_bank_wr_cta;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stage_start = 1'b0;
  logic [2:0]         factor = '0;
  logic [11:0]        grp_num = '0;
  logic               in_val = 1'b0;
  logic signed [17:0] din_real [5];
  logic signed [17:0] din_imag [5];
  logic [11:0]        addr_in  [5];
  logic [4:0]         wr_en;
  logic [11:0]        wr_addr  [5];
  logic signed [17:0] wr_real  [5];
  logic signed [17:0] wr_imag  [5];
  logic               busy, stage_done, err;
  logic [4:0]         bits_used;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                 m_busy, m_err;
  int                 m_fac, m_left, m_max, m_bits;
  logic signed [17:0] e_real [5];
  logic signed [17:0] e_imag [5];
  logic [11:0]        e_addr [5];

  rdx_bank_wr_cta dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stage_start (stage_start),
    .factor      (factor),
    .grp_num     (grp_num),
    .in_val      (in_val),
    .din_real    (din_real),
    .din_imag    (din_imag),
    .addr_in     (addr_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_real     (wr_real),
    .wr_imag     (wr_imag),
    .busy        (busy),
    .stage_done  (stage_done),
    .bits_used   (bits_used),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mag(input int x);
    return (x < 0) ? -x - 1 : x;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_fac = 0; m_left = 0; m_max = 0; m_bits = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(stage_done), 32'd0);
    chk({tag, ".bits"}, 32'(bits_used), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'd0);
      chk($sformatf("%s.re%0d", tag, i), 32'(wr_real[i]), 32'd0);
      chk($sformatf("%s.im%0d", tag, i), 32'(wr_imag[i]), 32'd0);
    end
  endtask

  task automatic rnd_data();
    for (int i = 0; i < 5; i++) begin
      din_real[i] = 18'($urandom);
      din_imag[i] = 18'($urandom);
      addr_in[i]  = 12'($urandom);
    end
  endtask

  // One clock: drive inputs, advance the model, check the registered outputs after the edge.
  task automatic step(input string tag, input bit start, input int fac, input int grp,
                      input bit v);
    logic [4:0] exp_en;
    bit         exp_done;
    stage_start = start;
    factor      = 3'(fac);
    grp_num     = 12'(grp);
    in_val      = v;
    exp_en      = '0;
    exp_done    = 0;
    if (start) begin
      if (m_busy || v || fac < 2 || fac > 5 || grp == 0) m_err = 1;
      m_fac  = (fac < 2) ? 2 : ((fac > 5) ? 5 : fac);
      m_left = (grp == 0) ? 1 : grp;
      m_max  = 0;
      m_busy = 1;
    end else if (v) begin
      if (!m_busy) m_err = 1;
      else begin
        exp_en = 5'((1 << m_fac) - 1);
        for (int i = 0; i < m_fac; i++) begin
          if (mag(int'(din_real[i])) > m_max) m_max = mag(int'(din_real[i]));
          if (mag(int'(din_imag[i])) > m_max) m_max = mag(int'(din_imag[i]));
          e_real[i] = din_real[i];
          e_imag[i] = din_imag[i];
          e_addr[i] = addr_in[i];
        end
        m_left--;
        if (m_left == 0) begin
          m_busy   = 0;
          exp_done = 1;
          m_bits   = $clog2(m_max + 1);
        end
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_en));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(stage_done), 32'(exp_done));
    chk({tag, ".bits"}, 32'(bits_used), 32'(m_bits));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    for (int i = 0; i < 5; i++) begin
      if (exp_en[i]) begin
        chk($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'(e_addr[i]));
        chk($sformatf("%s.re%0d", tag, i), 32'(wr_real[i]), 32'(e_real[i]));
        chk($sformatf("%s.im%0d", tag, i), 32'(wr_imag[i]), 32'(e_imag[i]));
      end
    end
    stage_start = 0;
    in_val      = 0;
  endtask

  task automatic zero_data();
    for (int i = 0; i < 5; i++) begin
      din_real[i] = '0; din_imag[i] = '0; addr_in[i] = '0;
    end
  endtask

  initial begin
    int f, g, k;
    zero_data();
    model_reset();
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full-radix stage with patterned data
    step("s5.start", 1, 5, 4, 0);
    for (int b = 0; b < 4; b++) begin
      rnd_data();
      for (int i = 0; i < 5; i++) begin
        din_real[i] = 18'(100 * i + b);
        addr_in[i]  = 12'(b);
      end
      step($sformatf("s5.b%0d", b), 0, 5, 4, 1);
    end
    step("s5.idle", 0, 5, 4, 0);

    // Radix 3: lanes 3,4 carry data but must never be written
    step("s3.start", 1, 3, 2, 0);
    for (int b = 0; b < 2; b++) begin
      rnd_data();
      step($sformatf("s3.b%0d", b), 0, 3, 2, 1);
    end

    // Headroom cases
    step("h10.start", 1, 2, 1, 0);
    rnd_data();
    din_real[0] = -18'sd1; din_imag[0] = '0; din_real[1] = '0; din_imag[1] = 18'sd1000;
    step("h10.beat", 0, 2, 1, 1);
    step("h0.start", 1, 2, 1, 0);
    zero_data();
    step("h0.beat", 0, 2, 1, 1);
    step("h17.start", 1, 4, 1, 0);
    zero_data();
    din_imag[3] = 18'sd131071;
    step("h17.beat", 0, 4, 1, 1);
    step("hneg.start", 1, 5, 1, 0);
    zero_data();
    din_real[4] = -18'sd131072;
    step("hneg.beat", 0, 5, 1, 1);

    // Back-to-back: start in the DONE cycle
    step("bb.start", 1, 4, 2, 0);
    rnd_data(); step("bb.b0", 0, 4, 2, 1);
    rnd_data(); step("bb.b1", 0, 4, 2, 1);
    step("bb.restart", 1, 2, 3, 0);
    for (int b = 0; b < 3; b++) begin
      rnd_data();
      step($sformatf("bb2.b%0d", b), 0, 2, 3, 1);
    end

    // Randomized legal stages with gaps
    for (int s = 0; s < 6; s++) begin
      f = $urandom_range(2, 5);
      g = $urandom_range(1, 6);
      step($sformatf("r%0d.start", s), 1, f, g, 0);
      k = 0;
      for (int c = 0; c < 40 && k < g; c++) begin
        rnd_data();
        if ($urandom_range(0, 2) != 0) begin
          step($sformatf("r%0d.b%0d", s, k), 0, f, g, 1);
          k++;
        end else begin
          step($sformatf("r%0d.gap", s), 0, f, g, 0);
        end
      end
      chk($sformatf("r%0d.beats", s), 32'(k), 32'(g));
      step($sformatf("r%0d.idle", s), 0, f, g, 0);
    end

    // Overrun: third beat lands in DONE, error becomes sticky
    step("ov.start", 1, 3, 2, 0);
    for (int b = 0; b < 3; b++) begin
      rnd_data();
      step($sformatf("ov.b%0d", b), 0, 3, 2, 1);
    end
    step("ov.hold", 0, 3, 2, 0);

    // Illegal parameters at stage_start
    step("fhi.start", 1, 7, 1, 0);
    rnd_data(); step("fhi.beat", 0, 7, 1, 1);
    step("flo.start", 1, 1, 1, 0);
    rnd_data(); step("flo.beat", 0, 1, 1, 1);
    step("g0.start", 1, 4, 0, 0);
    rnd_data(); step("g0.beat", 0, 4, 0, 1);
    step("under.start", 1, 5, 3, 0);
    rnd_data(); step("under.b0", 0, 5, 3, 1);
    step("under.restart", 1, 5, 2, 0);
    rnd_data(); step("startval", 0, 5, 2, 1);
    rnd_data(); step("startval.b1", 0, 5, 2, 1);
    rnd_data(); step("idle.val", 0, 5, 2, 1);

    // Async reset between edges mid-stage
    step("ar.start", 1, 5, 4, 0);
    rnd_data(); step("ar.b0", 0, 5, 4, 1);
    rnd_data(); step("ar.b1", 0, 5, 4, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("ar.async");
    @(posedge clk);
    #1;
    chk("ar.nodone", 32'(stage_done), 32'd0);
    chk("ar.nobusy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("fresh.start", 1, 3, 2, 0);
    rnd_data(); step("fresh.b0", 0, 3, 2, 1);
    rnd_data(); step("fresh.b1", 0, 3, 2, 1);
    step("fresh.idle", 0, 3, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
